// File: rtl/fir_mac_accumulator_pkg.sv
// Shared types and the round/shift/saturate helper for the FIR MAC accumulator.
package fir_pkg;

  localparam int PROD_W_DEF = 16;
  localparam int OUT_W_DEF  = 16;

  typedef enum logic {
    ACCUM  = 1'b0,
    OUTPUT = 1'b1
  } fir_state_e;

  // Flag sits in the LSB so a width cast keeps {value[OUT_W-1:0], flag}.
  typedef struct packed {
    logic [63:0] value;
    logic        flag;
  } sat_res_t;

  function automatic sat_res_t sat_round(input logic signed [63:0] acc,
                                         input int                 shift,
                                         input int                 out_w,
                                         input logic               sat_en);
    logic signed [63:0] r;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    sat_res_t           res;
    r = acc;
    if (shift > 0) begin
      r = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
    end
    max_v     = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    min_v     = -(64'sd1 <<< (out_w - 1));
    res.flag  = (r > max_v) || (r < min_v);
    res.value = r;
    if (sat_en && (r > max_v)) begin
      res.value = max_v;
    end else if (sat_en && (r < min_v)) begin
      res.value = min_v;
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_mac_accumulator_adder.sv
// Plain two-operand adder reused from the combinational FIR adder stage.
module fir_mac_accumulator_adder #(
  parameter int WIDTH = 19
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/fir_mac_accumulator.sv
// Sequential FIR adder stage: sums NUM_TAPS products, then rounds, shifts and
// saturates/wraps the total into one output sample.
module fir_mac_accumulator
  import fir_pkg::*;
#(
  parameter int PROD_W    = PROD_W_DEF,
  parameter int NUM_TAPS  = 8,
  parameter int OUT_W     = OUT_W_DEF,
  parameter int OUT_SHIFT = 0,
  parameter int SAT_EN    = 1,
  localparam int ACC_W    = PROD_W + $clog2(NUM_TAPS),
  localparam int CNT_W    = $clog2(NUM_TAPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] mnozenie_wynik,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  suma_wynik,
  output logic              sat_flag,
  output logic [CNT_W-1:0]  tap_idx
);

  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(NUM_TAPS - 1);

  fir_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] tap_q, tap_d;
  logic [OUT_W-1:0] suma_q, suma_d;
  logic             sat_q, sat_d;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] acc_sum;
  logic [OUT_W-1:0] round_value;
  logic             round_flag;

  assign prod_ext = {{(ACC_W - PROD_W){mnozenie_wynik[PROD_W-1]}}, mnozenie_wynik};

  fir_mac_accumulator_adder #(
    .WIDTH(ACC_W)
  ) u_adder (
    .a  (acc_q),
    .b  (prod_ext),
    .sum(acc_sum)
  );

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // ready is a pure function of state, so products and samples never combine through.
  assign in_ready   = (state_q == ACCUM);
  assign out_valid  = (state_q == OUTPUT);
  assign suma_wynik = suma_q;
  assign sat_flag   = sat_q;
  assign tap_idx    = tap_q;

  always_comb begin
    {round_value, round_flag} = (OUT_W + 1)'(sat_round(64'(signed'(acc_sum)), OUT_SHIFT,
                                                       OUT_W, (SAT_EN != 0)));
    state_d = state_q;
    acc_d   = acc_q;
    tap_d   = tap_q;
    suma_d  = suma_q;
    sat_d   = sat_q;
    case (state_q)
      ACCUM: begin
        if (in_valid) begin
          if (tap_q == LAST_TAP) begin
            suma_d  = round_value;
            sat_d   = round_flag;
            acc_d   = '0;
            tap_d   = '0;
            state_d = OUTPUT;
          end else begin
            acc_d = acc_sum;
            tap_d = tap_q + CNT_W'(1);
          end
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      tap_q   <= '0;
      suma_q  <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      tap_q   <= tap_d;
      suma_q  <= suma_d;
      sat_q   <= sat_d;
    end
  end

endmodule

// File: tb/tb_fir_mac_accumulator.sv
// Bench for fir_mac_accumulator: three configurations share one stimulus stream
// (saturate, wrap, shift-by-2 with saturate) and are checked against an arithmetic model.
module tb_fir_mac_accumulator;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               out_ready = 1'b1;
  logic signed [15:0] mnozenie_wynik = '0;
  logic [2:0]         in_ready;
  logic [2:0]         out_valid;
  logic [2:0]         sat_flag;
  logic [15:0]        suma [3];
  logic [2:0]         tap [3];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [16:0] exp0_q[$];
  logic [16:0] exp1_q[$];
  logic [16:0] exp2_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  fir_mac_accumulator #(.OUT_SHIFT(0), .SAT_EN(1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
    .mnozenie_wynik(mnozenie_wynik), .out_valid(out_valid[0]), .out_ready(out_ready),
    .suma_wynik(suma[0]), .sat_flag(sat_flag[0]), .tap_idx(tap[0]));

  fir_mac_accumulator #(.OUT_SHIFT(0), .SAT_EN(0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
    .mnozenie_wynik(mnozenie_wynik), .out_valid(out_valid[1]), .out_ready(out_ready),
    .suma_wynik(suma[1]), .sat_flag(sat_flag[1]), .tap_idx(tap[1]));

  fir_mac_accumulator #(.OUT_SHIFT(2), .SAT_EN(1)) u_shift (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]),
    .mnozenie_wynik(mnozenie_wynik), .out_valid(out_valid[2]), .out_ready(out_ready),
    .suma_wynik(suma[2]), .sat_flag(sat_flag[2]), .tap_idx(tap[2]));

  // Reference: exact integer sum, floor((s + d/2) / d), then clip or wrap to 16 bits.
  function automatic logic [16:0] ref_sample(input longint s, input int shift, input bit sat);
    longint r, d, w;
    bit     f;
    r = s;
    if (shift > 0) begin
      d = longint'(1) << shift;
      r = s + d / 2;
      r = (r - (((r % d) + d) % d)) / d;
    end
    if (sat) begin
      f = 1'b0;
      if (r > 32767) begin
        r = 32767;
        f = 1'b1;
      end else if (r < -32768) begin
        r = -32768;
        f = 1'b1;
      end
      w = r;
    end else begin
      w = r & 64'hFFFF;
      if (w >= 32768) w = w - 65536;
      f = (w != r);
    end
    return {f, w[15:0]};
  endfunction

  task automatic push_expect(input longint s);
    exp0_q.push_back(ref_sample(s, 0, 1'b1));
    exp1_q.push_back(ref_sample(s, 0, 1'b0));
    exp2_q.push_back(ref_sample(s, 2, 1'b1));
  endtask

  // Called at a negedge; returns at the negedge after the product was accepted.
  task automatic drive_product(input logic signed [15:0] p, output bit ok);
    bit acc;
    in_valid = 1'b1;
    mnozenie_wynik = p;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      acc = in_ready[0];
      @(posedge clk);
      @(negedge clk);
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL drive_accept: product %0d not accepted within 50 cycles", p);
    end
  endtask

  task automatic send_sample(input logic signed [15:0] p [8], input int gap_max,
                             input bit push, output int done_cyc);
    longint s;
    bit     ok;
    int     g;
    s = 0;
    foreach (p[i]) s += p[i];
    if (push) push_expect(s);
    for (int i = 0; i < 8; i++) begin
      if (gap_max > 0) begin
        g = $urandom_range(0, gap_max);
        in_valid = 1'b0;
        repeat (g) @(negedge clk);
      end
      n_cmp++;
      if (in_ready[0] && tap[0] !== 3'(i)) begin
        n_err++;
        $display("FAIL tap_idx: got %0d expected %0d", tap[0], i);
      end
      drive_product(p[i], ok);
    end
    in_valid = 1'b0;
    done_cyc = cyc;
    n_cmp++;
    if (out_valid !== 3'b111) begin
      n_err++;
      $display("FAIL latency: out_valid=%b expected 111 one cycle after last accept", out_valid);
    end
  endtask

  task automatic check_output(input string name, input int hold);
    logic [16:0] e [3];
    logic [15:0] held;
    for (int t = 0; t < 20 && out_valid[0] !== 1'b1; t++) @(negedge clk);
    n_cmp++;
    if (out_valid !== 3'b111 || exp0_q.size() == 0) begin
      n_err++;
      $display("FAIL %s_valid: out_valid=%b, %0d expectations queued", name, out_valid,
               exp0_q.size());
      return;
    end
    e[0] = exp0_q.pop_front();
    e[1] = exp1_q.pop_front();
    e[2] = exp2_q.pop_front();
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if ({sat_flag[k], suma[k]} !== e[k]) begin
        n_err++;
        $display("FAIL %s_dut%0d: got sample %0d flag %b expected sample %0d flag %b", name, k,
                 $signed(suma[k]), sat_flag[k], $signed(e[k][15:0]), e[k][16]);
      end
    end
    held = suma[0];
    repeat (hold) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 3'b111 || suma[0] !== held || in_ready !== 3'b000 || tap[0] !== 3'd0) begin
        n_err++;
        $display("FAIL %s_hold: out_valid=%b in_ready=%b sample %0d expected %0d tap %0d", name,
                 out_valid, in_ready, $signed(suma[0]), $signed(held), tap[0]);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 3'b000 || in_ready !== 3'b111) begin
      n_err++;
      $display("FAIL %s_drop: out_valid=%b in_ready=%b expected 000/111", name, out_valid,
               in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    mnozenie_wynik = 16'sd5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 3'b000 || in_ready !== 3'b111 || sat_flag !== 3'b000) begin
      n_err++;
      $display("FAIL reset_ctrl: out_valid=%b in_ready=%b sat_flag=%b expected 000/111/000",
               out_valid, in_ready, sat_flag);
    end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (suma[k] !== 16'd0 || tap[k] !== 3'd0) begin
        n_err++;
        $display("FAIL reset_dut%0d: sample %0d tap %0d expected 0/0", k, suma[k], tap[k]);
      end
    end
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 3'b111 || tap[0] !== 3'd0) begin
      n_err++;
      $display("FAIL reset_release: in_ready=%b tap %0d expected 111/0", in_ready, tap[0]);
    end
  endtask

  task automatic test_basic();
    logic signed [15:0] p [8];
    int c;
    p = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5, 16'sd6, 16'sd7, 16'sd8};
    out_ready = 1'b1;
    send_sample(p, 0, 1'b1, c);
    n_cmp++;
    if (suma[0] !== 16'd36 || sat_flag[0] !== 1'b0) begin
      n_err++;
      $display("FAIL basic_const: got %0d flag %b expected 36 flag 0", $signed(suma[0]),
               sat_flag[0]);
    end
    check_output("basic", 0);
  endtask

  task automatic test_saturation();
    logic signed [15:0] p [8];
    int c;
    out_ready = 1'b1;
    foreach (p[i]) p[i] = 16'sd30000;
    send_sample(p, 0, 1'b1, c);
    n_cmp++;
    if (suma[0] !== 16'h7FFF || sat_flag[0] !== 1'b1 || suma[1] !== 16'hA980 ||
        sat_flag[1] !== 1'b1) begin
      n_err++;
      $display("FAIL sat_pos: sat %0d/%b wrap %0d/%b expected 32767/1 -22144/1",
               $signed(suma[0]), sat_flag[0], $signed(suma[1]), sat_flag[1]);
    end
    check_output("sat_pos", 0);
    foreach (p[i]) p[i] = -16'sd30000;
    send_sample(p, 0, 1'b1, c);
    n_cmp++;
    if (suma[0] !== 16'h8000 || sat_flag[0] !== 1'b1) begin
      n_err++;
      $display("FAIL sat_neg: got %0d flag %b expected -32768 flag 1", $signed(suma[0]),
               sat_flag[0]);
    end
    check_output("sat_neg", 0);
  endtask

  task automatic test_round();
    logic signed [15:0] p [8];
    int c;
    out_ready = 1'b1;
    p = '{16'sd5, 16'sd5, 16'sd5, 16'sd5, 16'sd5, 16'sd5, 16'sd5, 16'sd2};
    send_sample(p, 0, 1'b1, c);
    n_cmp++;
    if (suma[2] !== 16'd9 || sat_flag[2] !== 1'b0) begin
      n_err++;
      $display("FAIL round_pos: got %0d flag %b expected 9 flag 0", $signed(suma[2]),
               sat_flag[2]);
    end
    check_output("round_pos", 0);
    p = '{-16'sd1, -16'sd1, -16'sd1, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
    send_sample(p, 0, 1'b1, c);
    n_cmp++;
    if (suma[2] !== 16'hFFFF || sat_flag[2] !== 1'b0) begin
      n_err++;
      $display("FAIL round_neg: got %0d flag %b expected -1 flag 0", $signed(suma[2]),
               sat_flag[2]);
    end
    check_output("round_neg", 0);
  endtask

  task automatic test_backpressure();
    logic signed [15:0] p [8];
    int c;
    foreach (p[i]) p[i] = 16'($urandom_range(0, 65535));
    out_ready = 1'b0;
    send_sample(p, 0, 1'b1, c);
    in_valid = 1'b1;
    mnozenie_wynik = 16'sd1234;
    check_output("backpressure", 5);
    p[0] = 16'sd1234;
    for (int i = 1; i < 8; i++) p[i] = 16'($urandom_range(0, 65535));
    send_sample(p, 0, 1'b1, c);
    check_output("after_bp", 0);
  endtask

  task automatic test_back_to_back();
    logic signed [15:0] p [8];
    int c [3];
    out_ready = 1'b1;
    for (int s = 0; s < 3; s++) begin
      foreach (p[i]) p[i] = 16'($urandom_range(0, 65535));
      send_sample(p, 0, 1'b1, c[s]);
      check_output("b2b", 0);
    end
    for (int s = 1; s < 3; s++) begin
      n_cmp++;
      if (c[s] - c[s-1] !== 9) begin
        n_err++;
        $display("FAIL b2b_period: %0d cycles between samples expected 9", c[s] - c[s-1]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic signed [15:0] p [8];
    int c;
    bit ok;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) drive_product(16'($urandom_range(0, 65535)), ok);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (tap[0] !== 3'd0 || out_valid !== 3'b000) begin
      n_err++;
      $display("FAIL midreset_accum: tap %0d out_valid=%b expected 0/000", tap[0], out_valid);
    end
    foreach (p[i]) p[i] = 16'($urandom_range(0, 65535));
    send_sample(p, 0, 1'b1, c);
    check_output("fresh_sum", 0);
    out_ready = 1'b0;
    send_sample(p, 0, 1'b0, c);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (out_valid !== 3'b000 || suma[0] !== 16'd0 || sat_flag !== 3'b000) begin
      n_err++;
      $display("FAIL midreset_output: out_valid=%b sample %0d sat=%b expected 000/0/000",
               out_valid, $signed(suma[0]), sat_flag);
    end
    out_ready = 1'b1;
    p = '{16'sd100, -16'sd7, 16'sd3, 16'sd0, -16'sd50, 16'sd9, 16'sd1, 16'sd2};
    send_sample(p, 0, 1'b1, c);
    check_output("post_reset", 0);
  endtask

  task automatic test_random();
    logic signed [15:0] p [8];
    int c, hold, mode;
    for (int s = 0; s < 20; s++) begin
      mode = $urandom_range(0, 2);
      foreach (p[i]) begin
        if (mode == 0) p[i] = 16'($urandom_range(0, 65535));
        else if (mode == 1) p[i] = 16'($signed($urandom_range(0, 64)) - 32);
        else p[i] = 16'($urandom_range(28000, 32767)) * ((s % 2 == 1) ? -16'sd1 : 16'sd1);
      end
      hold = $urandom_range(0, 3);
      out_ready = (hold == 0);
      send_sample(p, 2, 1'b1, c);
      check_output("random", hold);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_round();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
